uz_nn_acc_hls_deadlock_report_ctrl: RTL and testbench
=====================================================

# uz_NN_acc_hls_deadlock_report_ctrl

Central controller for the per-process HLS deadlock detection units. It watches every unit's detect output, arbitrates one origin process, and broadcasts the global detect flag. It then launches and traces the report token, clears the token when it returns to the origin, and presents a latched deadlock report (origin ID and participating-process mask) to the debug/status register bank. It sits at the top of the uz_NN_acc dataflow region, one instance per region.

## Interface
Parameters:
- PROC_NUM, 4, number of dataflow processes/detection units (≥2)
- ID_W, 2, width of origin ID; must satisfy 2^ID_W ≥ PROC_NUM
- CNT_W, 8, trace timeout counter width; timeout at count 2^CNT_W−1

Ports:
- clock  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-low
- dl_detect_vec  in  PROC_NUM  bit p = detect output of unit p
- token_seen_vec  in  PROC_NUM  bit p = OR of unit p's incoming token vector
- report_ack  in  1  report consumed by status logic
- dl_detect_global  out  1  broadcast to every unit's detect input
- origin_vec  out  PROC_NUM  one-hot origin strobe to units
- token_clear_vec  out  PROC_NUM  one-hot token clear to units (combinational)
- dl_valid  out  1  report valid
- dl_origin_id  out  ID_W  index of origin process
- dl_cycle_mask  out  PROC_NUM  processes the token visited, origin included
- dl_timeout  out  1  report closed by timeout, not token return
- busy  out  1  state ≠ IDLE

## Operation
- FSM states:
  - IDLE: when dl_detect_vec ≠ 0, latch origin = lowest set index, mask = one-hot(origin), clear counter, go to ORIGIN.
  - ORIGIN: exactly one cycle; origin_vec = one-hot(origin); go to TRACE.
  - TRACE: each cycle mask |= token_seen_vec; counter += 1 (saturating).
    - If dl_detect_vec[origin] = 1: token_clear_vec = one-hot(origin) in that same cycle, mask includes that cycle's token_seen_vec, dl_timeout ← 0, go to REPORT.
    - Else if counter = 2^CNT_W−1: dl_timeout ← 1, go to REPORT.
  - REPORT: dl_valid = 1; dl_origin_id, dl_cycle_mask and dl_timeout stable; on report_ack go to IDLE.
- dl_detect_global = 1 in ORIGIN, TRACE and REPORT. Units hold their dependency state until it drops.
- token_clear_vec is non-zero only in TRACE, on the return cycle. origin_vec is non-zero only in ORIGIN.
- In TRACE, detect bits of non-origin units are ignored. In REPORT and ORIGIN, all dl_detect_vec bits are ignored.
- report_ack outside REPORT has no effect.
- Return and timeout in the same cycle: return wins, dl_timeout = 0.
- Report registers keep their last value in IDLE. Only dl_valid marks them meaningful.

## Timing
- Reset (asynchronous, any state): state IDLE; all outputs 0, including dl_origin_id, dl_cycle_mask, dl_timeout and the counter.
- Detect seen at edge N: ORIGIN during cycle N+1, with dl_detect_global = 1 and origin_vec pulsed. TRACE starts at N+2, counter = 0.
- Return seen in TRACE during cycle M: token_clear_vec pulses in cycle M. dl_valid = 1 from cycle M+1.
- Timeout: at most 2^CNT_W cycles in TRACE.
- report_ack seen at edge K with dl_valid = 1: IDLE and dl_valid = 0 at K+1. Re-arbitration is possible at K+1, so a new ORIGIN at K+2.
- Minimum detect-to-report latency: 3 cycles.

## Test plan
- Reset mid-TRACE, PROC_NUM=4: assert reset → all outputs 0 immediately; after release busy = 0 and no report.
- dl_detect_vec=4'b0110 at edge N → origin_vec=4'b0010 in N+1 only; dl_detect_global=1 from N+1. token_seen_vec=4'b0100 at N+3, then dl_detect_vec[1]=1 at N+4 → token_clear_vec=4'b0010 at N+4; at N+5 dl_valid=1, dl_origin_id=1, dl_cycle_mask=4'b0110, dl_timeout=0.
- CNT_W=3, origin 0, no return → dl_valid with dl_timeout=1 after exactly 8 TRACE cycles; mask holds the tokens seen so far.
- Return on the same cycle the counter hits 7 → dl_timeout=0, token_clear_vec pulsed.
- Hold report_ack=0 for 20 cycles while dl_detect_vec toggles → report fields unchanged, no origin_vec. Pulse ack → dl_valid=0 next cycle; with dl_detect_vec=4'b1000 present, origin_vec=4'b1000 one cycle later.
- Non-origin detect (dl_detect_vec=4'b0100, origin 0) during TRACE → no token_clear_vec, stays in TRACE.

Source files
------------

// File: rtl/uz_nn_acc_hls_deadlock_report_ctrl.sv
// Deadlock report controller: arbitrates one origin among the detection units,
// traces the report token around the cycle and latches the origin/mask report.
module uz_nn_acc_hls_deadlock_report_ctrl #(
    parameter int PROC_NUM = 4,
    parameter int ID_W     = 2,
    parameter int CNT_W    = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [PROC_NUM-1:0] dl_detect_vec,
    input  logic [PROC_NUM-1:0] token_seen_vec,
    input  logic                report_ack,
    output logic                dl_detect_global,
    output logic [PROC_NUM-1:0] origin_vec,
    output logic [PROC_NUM-1:0] token_clear_vec,
    output logic                dl_valid,
    output logic [ID_W-1:0]     dl_origin_id,
    output logic [PROC_NUM-1:0] dl_cycle_mask,
    output logic                dl_timeout,
    output logic                busy,
    output logic [1:0]          dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ORIGIN = 2'd1,
        S_TRACE  = 2'd2,
        S_REPORT = 2'd3
    } state_t;

    localparam logic [PROC_NUM-1:0] ONE = {{(PROC_NUM-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ID_W-1:0]     origin_q, origin_d, first_id;
    logic [PROC_NUM-1:0] mask_q, mask_d, origin_oh, first_oh;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                tmo_q, tmo_d, returned, cnt_max;

    // Lowest set detect bit wins arbitration.
    always_comb begin
        first_id = '0;
        for (int i = PROC_NUM - 1; i >= 0; i--) begin
            if (dl_detect_vec[i]) first_id = ID_W'(i);
        end
    end

    assign first_oh  = ONE << first_id;
    assign origin_oh = ONE << origin_q;
    assign returned  = |(dl_detect_vec & origin_oh);
    assign cnt_max   = (cnt_q == {CNT_W{1'b1}});

    // Report handshake: dl_valid is held with stable fields until report_ack is
    // seen high on a rising edge; the report is then consumed and dl_valid drops.
    always_comb begin
        state_d         = state_q;
        origin_d        = origin_q;
        mask_d          = mask_q;
        cnt_d           = cnt_q;
        tmo_d           = tmo_q;
        origin_vec      = '0;
        token_clear_vec = '0;
        case (state_q)
            S_IDLE: begin
                if (|dl_detect_vec) begin
                    origin_d = first_id;
                    mask_d   = first_oh;
                    cnt_d    = '0;
                    state_d  = S_ORIGIN;
                end
            end
            S_ORIGIN: begin
                origin_vec = origin_oh;
                state_d    = S_TRACE;
            end
            S_TRACE: begin
                mask_d = mask_q | token_seen_vec;
                cnt_d  = cnt_max ? cnt_q : cnt_q + 1'b1;
                // Token return takes priority over a coincident timeout.
                if (returned) begin
                    token_clear_vec = origin_oh;
                    tmo_d           = 1'b0;
                    state_d         = S_REPORT;
                end else if (cnt_max) begin
                    tmo_d   = 1'b1;
                    state_d = S_REPORT;
                end
            end
            S_REPORT: begin
                if (report_ack) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            origin_q <= '0;
            mask_q   <= '0;
            cnt_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            origin_q <= origin_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            tmo_q    <= tmo_d;
        end
    end

    assign dl_detect_global = (state_q != S_IDLE);
    assign busy             = (state_q != S_IDLE);
    assign dl_valid         = (state_q == S_REPORT);
    assign dl_origin_id     = origin_q;
    assign dl_cycle_mask    = mask_q;
    assign dl_timeout       = tmo_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_uz_nn_acc_hls_deadlock_report_ctrl.sv
// Bench for the deadlock report controller: per-cycle vector table with an
// expected-output queue, plus a hand-written asynchronous reset sequence.
module tb_uz_nn_acc_hls_deadlock_report_ctrl;
    localparam int P  = 4;
    localparam int IW = 2;
    localparam int CW = 3;
    localparam int W  = 18;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic [P-1:0]  dl_detect_vec = '0;
    logic [P-1:0]  token_seen_vec = '0;
    logic          report_ack = 1'b0;
    logic          dl_detect_global;
    logic [P-1:0]  origin_vec, token_clear_vec, dl_cycle_mask;
    logic          dl_valid, dl_timeout, busy;
    logic [IW-1:0] dl_origin_id;
    logic [1:0]    dbg_state;

    uz_nn_acc_hls_deadlock_report_ctrl #(.PROC_NUM(P), .ID_W(IW), .CNT_W(CW)) dut (
        .clock            (clock),
        .reset            (reset),
        .dl_detect_vec    (dl_detect_vec),
        .token_seen_vec   (token_seen_vec),
        .report_ack       (report_ack),
        .dl_detect_global (dl_detect_global),
        .origin_vec       (origin_vec),
        .token_clear_vec  (token_clear_vec),
        .dl_valid         (dl_valid),
        .dl_origin_id     (dl_origin_id),
        .dl_cycle_mask    (dl_cycle_mask),
        .dl_timeout       (dl_timeout),
        .busy             (busy),
        .dbg_state        (dbg_state)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [P-1:0] det;
        logic [P-1:0] seen;
        logic         ack;
        logic [W-1:0] exp;
    } vec_t;

    vec_t         tbl[$];
    logic [W-1:0] exp_q[$];
    int           n_checks = 0;
    int           n_pass   = 0;

    // Packed layout: glob, origin_vec, clear_vec, valid, id, mask, timeout, busy
    function automatic logic [W-1:0] pk(input logic g, input logic [3:0] ov, input logic [3:0] clr,
                                        input logic v, input logic [1:0] id, input logic [3:0] m,
                                        input logic t, input logic b);
        return {g, ov, clr, v, id, m, t, b};
    endfunction

    function automatic logic [W-1:0] idle(input logic [1:0] id, input logic [3:0] m, input logic t);
        return pk(1'b0, 4'b0, 4'b0, 1'b0, id, m, t, 1'b0);
    endfunction

    function automatic logic [W-1:0] orig(input logic [3:0] ov, input logic [1:0] id, input logic [3:0] m, input logic t);
        return pk(1'b1, ov, 4'b0, 1'b0, id, m, t, 1'b1);
    endfunction

    function automatic logic [W-1:0] trc(input logic [3:0] clr, input logic [1:0] id, input logic [3:0] m, input logic t);
        return pk(1'b1, 4'b0, clr, 1'b0, id, m, t, 1'b1);
    endfunction

    function automatic logic [W-1:0] rpt(input logic [1:0] id, input logic [3:0] m, input logic t);
        return pk(1'b1, 4'b0, 4'b0, 1'b1, id, m, t, 1'b1);
    endfunction

    task automatic add(input logic [3:0] det, input logic [3:0] seen, input logic ack, input logic [W-1:0] e);
        vec_t v;
        v.det  = det;
        v.seen = seen;
        v.ack  = ack;
        v.exp  = e;
        tbl.push_back(v);
    endtask

    task automatic check(input string name);
        logic [W-1:0] a, e;
        a = pk(dl_detect_global, origin_vec, token_clear_vec, dl_valid, dl_origin_id,
               dl_cycle_mask, dl_timeout, busy);
        n_checks++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: no expected entry queued, got %h", name, a);
        end else begin
            e = exp_q.pop_front();
            if (a === e) n_pass++;
            else $display("FAIL %s: got %h required %h (glob,ovec,clr,valid,id,mask,tmo,busy)", name, a, e);
        end
    endtask

    initial begin
        repeat (2) @(negedge clock);
        exp_q.push_back(idle(2'd0, 4'b0, 1'b0));
        #1 check("reset_state");
        reset = 1'b1;

        // Traced return: origin 1, token seen at unit 2, ack outside REPORT ignored
        add(4'b0110, 4'b0000, 1'b0, idle(2'd0, 4'b0000, 1'b0));
        add(4'b0000, 4'b0000, 1'b0, orig(4'b0010, 2'd1, 4'b0010, 1'b0));
        add(4'b0000, 4'b0000, 1'b0, trc(4'b0000, 2'd1, 4'b0010, 1'b0));
        add(4'b0000, 4'b0100, 1'b1, trc(4'b0000, 2'd1, 4'b0010, 1'b0));
        add(4'b0010, 4'b0000, 1'b0, trc(4'b0010, 2'd1, 4'b0110, 1'b0));
        add(4'b1111, 4'b0000, 1'b0, rpt(2'd1, 4'b0110, 1'b0));
        add(4'b0000, 4'b0000, 1'b1, rpt(2'd1, 4'b0110, 1'b0));
        add(4'b0000, 4'b0000, 1'b0, idle(2'd1, 4'b0110, 1'b0));

        // Timeout: origin 0, non-origin detect ignored, 8 TRACE cycles
        add(4'b0001, 4'b0000, 1'b0, idle(2'd1, 4'b0110, 1'b0));
        add(4'b0000, 4'b0000, 1'b0, orig(4'b0001, 2'd0, 4'b0001, 1'b0));
        add(4'b0100, 4'b0000, 1'b0, trc(4'b0000, 2'd0, 4'b0001, 1'b0));
        add(4'b0100, 4'b1000, 1'b0, trc(4'b0000, 2'd0, 4'b0001, 1'b0));
        add(4'b0000, 4'b0000, 1'b0, trc(4'b0000, 2'd0, 4'b1001, 1'b0));
        for (int i = 0; i < 4; i++) add(4'b0000, 4'b0000, 1'b0, trc(4'b0000, 2'd0, 4'b1001, 1'b0));
        add(4'b0000, 4'b0010, 1'b0, trc(4'b0000, 2'd0, 4'b1001, 1'b0));

        // Report held 20 cycles with no ack while detects toggle
        for (int i = 0; i < 20; i++)
            add(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b0, rpt(2'd0, 4'b1011, 1'b1));
        add(4'b1000, 4'b0000, 1'b1, rpt(2'd0, 4'b1011, 1'b1));
        add(4'b1000, 4'b0000, 1'b0, idle(2'd0, 4'b1011, 1'b1));
        add(4'b0000, 4'b0000, 1'b0, orig(4'b1000, 2'd3, 4'b1000, 1'b1));

        // Return on the same cycle the counter reaches its maximum
        for (int i = 0; i < 7; i++) add(4'b0000, 4'b0000, 1'b0, trc(4'b0000, 2'd3, 4'b1000, 1'b1));
        add(4'b1000, 4'b0000, 1'b0, trc(4'b1000, 2'd3, 4'b1000, 1'b1));
        add(4'b0000, 4'b0000, 1'b1, rpt(2'd3, 4'b1000, 1'b0));
        add(4'b0000, 4'b0000, 1'b0, idle(2'd3, 4'b1000, 1'b0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clock);
            dl_detect_vec  = tbl[i].det;
            token_seen_vec = tbl[i].seen;
            report_ack     = tbl[i].ack;
            exp_q.push_back(tbl[i].exp);
            #1 check($sformatf("vec%0d", i));
        end

        // Asynchronous reset while tracing origin 2
        @(negedge clock);
        dl_detect_vec  = 4'b0100;
        token_seen_vec = 4'b0000;
        report_ack     = 1'b0;
        exp_q.push_back(idle(2'd3, 4'b1000, 1'b0));
        #1 check("rst_seq_idle");
        @(negedge clock);
        dl_detect_vec = 4'b0000;
        exp_q.push_back(orig(4'b0100, 2'd2, 4'b0100, 1'b0));
        #1 check("rst_seq_origin");
        @(negedge clock);
        exp_q.push_back(trc(4'b0000, 2'd2, 4'b0100, 1'b0));
        #1 check("rst_seq_trace");
        #2 reset = 1'b0;
        exp_q.push_back(idle(2'd0, 4'b0000, 1'b0));
        #1 check("reset_async");
        @(negedge clock);
        reset = 1'b1;
        exp_q.push_back(idle(2'd0, 4'b0000, 1'b0));
        #1 check("after_reset");
        @(negedge clock);
        exp_q.push_back(idle(2'd0, 4'b0000, 1'b0));
        #1 check("after_reset_idle");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
